// File: rtl/ref_burst_scheduler.sv
// ref_burst_scheduler: splits a bulk read into 4KB-safe AXI bursts for one arbiter port and streams the data back
// cmd_*: bulk command (start address, beat count); rd_id/addr/len/info_*: burst requests to the arbiter
// rd_data_*: returned beats; data_*: beats to the consumer with last flag; busy_out/done_out: command status
module ref_burst_scheduler #(
  parameter int ID_WIDTH = 4,
  parameter int MAX_BURST = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [32:0]         cmd_addr_in,
  input  logic [31:0]         cmd_beats_in,
  input  logic                cmd_valid_in,
  output logic                cmd_rdy_out,
  output logic [ID_WIDTH-1:0] rd_id_out,
  output logic [32:0]         rd_addr_out,
  output logic [7:0]          rd_len_out,
  output logic                rd_info_valid_out,
  input  logic                rd_info_rdy_in,
  input  logic [255:0]        rd_data_in,
  input  logic                rd_data_valid_in,
  output logic                rd_data_rdy_out,
  output logic [255:0]        data_out,
  output logic                data_valid_out,
  output logic                data_last_out,
  input  logic                data_rdy_in,
  output logic                busy_out,
  output logic                done_out
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;
  state_t state, state_nx;
  logic [32:0] addr;
  logic [31:0] remaining, total, received, room, cap, len;
  logic [OW-1:0] outstanding;
  logic [ID_WIDTH-1:0] tag;
  logic fits, req, beat, cmd_go, zero_go;
  // room is the beats left before the next 4KB page; it also caps the burst
  always_comb begin
    room = 32'd128 - 32'(addr[11:5]);
    cap = room < 32'(MAX_BURST) ? room : 32'(MAX_BURST);
    len = remaining < cap ? remaining : cap;
    fits = 32'(outstanding) + len <= 32'(MAX_OUTSTANDING);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && cmd_go) state_nx = ISSUE;
    if (state == ISSUE && req && remaining == len) state_nx = WAIT_DATA;
    if (state == WAIT_DATA && beat && data_last_out) state_nx = IDLE;
  end
  // valid stays high once raised: len is frozen until the handshake and outstanding can only fall
  always_comb begin
    busy_out = state != IDLE;
    cmd_rdy_out = state == IDLE;
    cmd_go = cmd_valid_in && cmd_rdy_out && cmd_beats_in != 32'd0;
    zero_go = cmd_valid_in && cmd_rdy_out && cmd_beats_in == 32'd0;
    rd_info_valid_out = state == ISSUE && fits;
    rd_addr_out = addr;
    rd_len_out = 8'(len - 32'd1);
    rd_id_out = tag;
    req = rd_info_valid_out && rd_info_rdy_in;
    data_out = rd_data_in;
    data_valid_out = rd_data_valid_in && busy_out;
    rd_data_rdy_out = data_rdy_in && busy_out;
    beat = rd_data_valid_in && rd_data_rdy_out;
    data_last_out = data_valid_out && received == total - 32'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      remaining <= '0;
      total <= '0;
      received <= '0;
      outstanding <= '0;
      tag <= '0;
      done_out <= 1'b0;
    end else begin
      done_out <= zero_go || (state == WAIT_DATA && beat && data_last_out);
      if (cmd_go) begin
        addr <= cmd_addr_in & ~33'h1f;
        remaining <= cmd_beats_in;
        total <= cmd_beats_in;
        received <= '0;
        outstanding <= '0;
      end else begin
        if (req) begin
          addr <= addr + 33'({len, 5'd0});
          remaining <= remaining - len;
          tag <= tag + ID_WIDTH'(1);
        end
        if (beat) received <= received + 32'd1;
        outstanding <= outstanding + (req ? OW'(len) : OW'(0)) - OW'(beat);
      end
    end
  end
endmodule

// File: tb/tb_ref_burst_scheduler.sv
// tb_ref_burst_scheduler: directed bench for ref_burst_scheduler with an arbiter/memory responder
module tb_ref_burst_scheduler;
  localparam int MO = 32;
  typedef struct packed {logic [32:0] a; logic [7:0] l; logic [3:0] id;} req_t;
  logic clk, rst_n;
  logic [32:0] cmd_addr_in;
  logic [31:0] cmd_beats_in;
  logic cmd_valid_in, cmd_rdy_out;
  logic [3:0] rd_id_out;
  logic [32:0] rd_addr_out;
  logic [7:0] rd_len_out;
  logic rd_info_valid_out, rd_info_rdy_in;
  logic [255:0] rd_data_in, data_out;
  logic rd_data_valid_in, rd_data_rdy_out;
  logic data_valid_out, data_last_out, data_rdy_in, busy_out, done_out;
  int vectors = 0, miscompares = 0;
  req_t req_q[$];
  logic [32:0] beat_q[$];
  int rx_cnt = 0, issued = 0, last_cnt = 0, last_at = 0, bad = 0, ovf = 0, done_cnt = 0;
  int req_base, rx_base, last_base, bad_base, ovf_base, done_base, o_base, rx_total;
  int beat_rd = 0, serve_left = 1000000;
  logic [32:0] cmd_start = '0;
  bit mem_en;

  ref_burst_scheduler #(.ID_WIDTH(4), .MAX_BURST(16), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr_in(cmd_addr_in), .cmd_beats_in(cmd_beats_in), .cmd_valid_in(cmd_valid_in), .cmd_rdy_out(cmd_rdy_out),
    .rd_id_out(rd_id_out), .rd_addr_out(rd_addr_out), .rd_len_out(rd_len_out),
    .rd_info_valid_out(rd_info_valid_out), .rd_info_rdy_in(rd_info_rdy_in),
    .rd_data_in(rd_data_in), .rd_data_valid_in(rd_data_valid_in), .rd_data_rdy_out(rd_data_rdy_out),
    .data_out(data_out), .data_valid_out(data_valid_out), .data_last_out(data_last_out), .data_rdy_in(data_rdy_in),
    .busy_out(busy_out), .done_out(done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Logs requests, queues their beats for the responder, and checks each received beat
  always @(posedge clk) begin
    if (rd_info_valid_out && rd_info_rdy_in) begin
      if (issued - rx_cnt - o_base + int'(rd_len_out) + 1 > MO) ovf <= ovf + 1;
      req_q.push_back({rd_addr_out, rd_len_out, rd_id_out});
      for (int i = 0; i <= int'(rd_len_out); i++) beat_q.push_back(rd_addr_out + 33'(32 * i));
      issued <= issued + int'(rd_len_out) + 1;
    end
    if (rd_data_valid_in && rd_data_rdy_out) begin
      if (data_out[32:0] !== cmd_start + 33'(32 * (rx_cnt - rx_base)) || !data_valid_out) bad <= bad + 1;
      if (data_last_out) begin
        last_cnt <= last_cnt + 1;
        last_at <= rx_cnt + 1;
      end
      rx_cnt <= rx_cnt + 1;
    end
    if (done_out) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input int k, input logic [32:0] a, input logic [7:0] l, input logic [3:0] id);
    int idx = req_base + k;
    if (idx < req_q.size()) begin
      chk($sformatf("req%0d_addr", k), req_q[idx].a, a);
      chk($sformatf("req%0d_len", k), req_q[idx].l, l);
      chk($sformatf("req%0d_id", k), req_q[idx].id, id);
    end else chk($sformatf("req%0d_missing", k), req_q.size(), idx + 1);
  endtask

  task automatic cmd(input logic [32:0] a, input logic [31:0] n);
    req_base = req_q.size(); rx_base = rx_cnt; last_base = last_cnt; bad_base = bad;
    ovf_base = ovf; done_base = done_cnt; o_base = issued - rx_cnt; rx_total = n;
    cmd_start = a & ~33'h1f;
    cmd_addr_in = a; cmd_beats_in = n; cmd_valid_in = 1'b1;
    #1;
    chk("cmd_rdy", cmd_rdy_out, 1);
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
  endtask

  task automatic run(input int cycles, input bit tog, input bit stop);
    int d0 = done_cnt;
    bit took;
    for (int c = 0; c < cycles; c++) begin
      if (stop && done_cnt != d0) break;
      if (tog) data_rdy_in = c[0] == 1'b0;
      rd_data_valid_in = mem_en && serve_left > 0 && beat_rd < beat_q.size();
      rd_data_in = rd_data_valid_in ? {223'd0, beat_q[beat_rd]} : '0;
      #1;
      if (tog && rx_cnt - rx_base < rx_total) chk("rdy_mirror", rd_data_rdy_out, data_rdy_in);
      took = rd_data_valid_in && rd_data_rdy_out;
      @(posedge clk); #1;
      if (took) begin
        beat_rd++;
        serve_left--;
      end
    end
    rd_data_valid_in = 1'b0;
    if (stop) chk("done_timeout", done_cnt != d0, 1);
  endtask

  task automatic finish_chk(input string t, input int nreq, input int nbeat);
    chk({t, "_reqs"}, req_q.size() - req_base, nreq);
    chk({t, "_beats"}, rx_cnt - rx_base, nbeat);
    chk({t, "_last_cnt"}, last_cnt - last_base, 1);
    chk({t, "_last_at"}, last_at - rx_base, nbeat);
    chk({t, "_order"}, bad - bad_base, 0);
    chk({t, "_outstanding"}, ovf - ovf_base, 0);
    chk({t, "_done"}, done_cnt - done_base, 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_addr_in = '0; cmd_beats_in = '0; cmd_valid_in = 1'b0;
    rd_info_rdy_in = 1'b1; rd_data_in = '0; rd_data_valid_in = 1'b1; data_rdy_in = 1'b1; mem_en = 1'b1;
    #12;
    chk("rst_cmd_rdy", cmd_rdy_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_info_valid", rd_info_valid_out, 0);
    chk("rst_id", rd_id_out, 0);
    chk("rst_data_rdy", rd_data_rdy_out, 0);
    chk("rst_data_valid", data_valid_out, 0);
    rd_data_valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // 40 beats from 0: 16,16,8
    cmd(33'h0, 40);
    chk("t1_busy", busy_out, 1);
    run(300, 0, 1);
    chk_req(0, 33'h000, 8'd15, 4'd0);
    chk_req(1, 33'h200, 8'd15, 4'd1);
    chk_req(2, 33'h400, 8'd7, 4'd2);
    finish_chk("t1", 3, 40);
    chk("t1_idle_cmd_rdy", cmd_rdy_out, 1);
    chk("t1_idle_data_rdy", rd_data_rdy_out, 0);
    chk("t1_idle_busy", busy_out, 0);
    // 4KB boundary split
    cmd(33'hFC0, 10);
    run(200, 0, 1);
    chk_req(0, 33'hFC0, 8'd1, 4'd3);
    chk_req(1, 33'h1000, 8'd7, 4'd4);
    finish_chk("t2", 2, 10);
    // outstanding limit
    mem_en = 1'b0;
    cmd(33'h2000, 64);
    run(30, 0, 0);
    chk("t3_stall_reqs", req_q.size() - req_base, 2);
    chk("t3_stall_valid", rd_info_valid_out, 0);
    mem_en = 1'b1; serve_left = 16;
    run(40, 0, 0);
    chk("t3_after16_reqs", req_q.size() - req_base, 3);
    chk_req(2, 33'h2400, 8'd15, 4'd7);
    chk("t3_after16_valid", rd_info_valid_out, 0);
    serve_left = 1000000;
    run(300, 0, 1);
    chk_req(3, 33'h2600, 8'd15, 4'd8);
    finish_chk("t3", 4, 64);
    // arbiter back-pressure
    rd_info_rdy_in = 1'b0;
    cmd(33'h3000, 20);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", rd_info_valid_out, 1);
      chk("t4_hold_addr", rd_addr_out, 33'h3000);
      chk("t4_hold_len", rd_len_out, 8'd15);
      chk("t4_hold_id", rd_id_out, 4'd9);
      @(posedge clk); #1;
    end
    chk("t4_no_req", req_q.size() - req_base, 0);
    rd_info_rdy_in = 1'b1;
    @(posedge clk); #1;
    chk("t4_one_req", req_q.size() - req_base, 1);
    run(200, 0, 1);
    chk_req(1, 33'h3200, 8'd3, 4'd10);
    finish_chk("t4", 2, 20);
    // consumer toggling ready
    cmd(33'h4000, 20);
    run(300, 1, 1);
    data_rdy_in = 1'b1;
    chk_req(0, 33'h4000, 8'd15, 4'd11);
    chk_req(1, 33'h4200, 8'd3, 4'd12);
    finish_chk("t5", 2, 20);
    // zero-beat command
    cmd(33'h5000, 0);
    chk("t6_done_pulse", done_out, 1);
    chk("t6_busy", busy_out, 0);
    @(posedge clk); #1;
    chk("t6_done_clear", done_out, 0);
    run(5, 0, 0);
    chk("t6_no_req", req_q.size() - req_base, 0);
    chk("t6_done_cnt", done_cnt - done_base, 1);
    // abort mid-command
    cmd(33'h6000, 40);
    run(10, 0, 0);
    rst_n = 1'b0;
    rd_data_valid_in = 1'b1;
    #1;
    chk("t7_rst_cmd_rdy", cmd_rdy_out, 1);
    chk("t7_rst_busy", busy_out, 0);
    chk("t7_rst_valid", rd_info_valid_out, 0);
    chk("t7_rst_id", rd_id_out, 0);
    chk("t7_rst_data_rdy", rd_data_rdy_out, 0);
    chk("t7_rst_data_valid", data_valid_out, 0);
    done_base = done_cnt;
    @(posedge clk); @(posedge clk); #1;
    rd_data_valid_in = 1'b0;
    beat_rd = beat_q.size();
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("t7_no_done", done_cnt - done_base, 0);
    cmd(33'h0, 20);
    run(200, 0, 1);
    chk_req(0, 33'h000, 8'd15, 4'd0);
    chk_req(1, 33'h200, 8'd3, 4'd1);
    finish_chk("t7", 2, 20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
